gpio_cfg_xfer: RTL and testbench



---
 rtl/gpio_cfg_pkg.sv | 29 ++
 rtl/gpio_cfg_cell.sv | 55 +++++
 rtl/gpio_cfg_xfer.sv | 134 +++++++++++++
 tb/tb_gpio_cfg_xfer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_cfg_pkg.sv
// rtl/gpio_cfg_pkg.sv - shared constants and FSM encoding for the GPIO config transfer engine
// Purpose: configuration word bit map, default word and transfer FSM state type.
// Ports: none (package).
package gpio_cfg_pkg;

  localparam int          CFG_W    = 13;
  localparam logic [12:0] CFG_INIT = 13'h0403;

  localparam int GPIO_MGMT_ENA    = 0;
  localparam int GPIO_OUTENB      = 1;
  localparam int GPIO_HOLDOVER    = 2;
  localparam int GPIO_INP_DIS     = 3;
  localparam int GPIO_IB_MODE_SEL = 4;
  localparam int GPIO_ANALOG_EN   = 5;
  localparam int GPIO_ANALOG_SEL  = 6;
  localparam int GPIO_ANALOG_POL  = 7;
  localparam int GPIO_SLOW_SEL    = 8;
  localparam int GPIO_VTRIP_SEL   = 9;
  localparam int GPIO_DM_LSB      = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_SHIFT,
    ST_LOAD
  } xfer_state_t;

endpackage

// File: rtl/gpio_cfg_cell.sv
// rtl/gpio_cfg_cell.sv - one pad's active config register and io_out/oeb ownership mux
// Purpose: holds the active word of a single pad, reloaded from the shadow chain on load.
// Ports: clk/rst (sync active-high), load strobe, shadow_word in; mgmt/user drive and
//        output-enable in; io_out, oeb and the per-pad control fields out (dm is 3 bits).
module gpio_cfg_cell
  import gpio_cfg_pkg::*;
#(
  parameter int               WORD_W    = 13,
  parameter logic [WORD_W-1:0] WORD_INIT = 13'h0403
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] shadow_word,
  input  logic              mgmt_io_out,
  input  logic              mgmt_oeb,
  input  logic              user_io_out,
  input  logic              user_oeb,
  output logic              io_out,
  output logic              oeb,
  output logic              inp_dis,
  output logic              ib_mode_sel,
  output logic              vtrip_sel,
  output logic              slow_sel,
  output logic              holdover,
  output logic              analog_en,
  output logic              analog_sel,
  output logic              analog_pol,
  output logic [2:0]        dm
);

  logic [WORD_W-1:0] active;

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= WORD_INIT;
    end else if (load) begin
      active <= shadow_word;
    end
  end

  // Management ownership keeps outenb as a hard disable on top of mgmt_oeb.
  assign io_out      = active[GPIO_MGMT_ENA] ? mgmt_io_out : user_io_out;
  assign oeb         = active[GPIO_MGMT_ENA] ? (active[GPIO_OUTENB] | mgmt_oeb) : user_oeb;
  assign inp_dis     = active[GPIO_INP_DIS];
  assign ib_mode_sel = active[GPIO_IB_MODE_SEL];
  assign vtrip_sel   = active[GPIO_VTRIP_SEL];
  assign slow_sel    = active[GPIO_SLOW_SEL];
  assign holdover    = active[GPIO_HOLDOVER];
  assign analog_en   = active[GPIO_ANALOG_EN];
  assign analog_sel  = active[GPIO_ANALOG_SEL];
  assign analog_pol  = active[GPIO_ANALOG_POL];
  assign dm          = active[GPIO_DM_LSB +: 3];

endmodule

// File: rtl/gpio_cfg_xfer.sv
// rtl/gpio_cfg_xfer.sv - serial per-pad GPIO configuration loader driving the mprj_io controls
// Purpose: on xfer_start reads one word per pad (pad N-1 down to 0), shifts it MSB first
//          through a shadow chain, then latches the whole chain into the pad cells at once.
// Ports: wb_clk_i/wb_rst_i (sync active-high); xfer_start in, xfer_busy/xfer_done out;
//        cfg_rd_en/cfg_rd_addr out, cfg_rd_data in (one-cycle read latency);
//        mgmt_/user_ io_out and oeb in; io_out, oeb, pad control vectors and dm (3/pad) out.
module gpio_cfg_xfer
  import gpio_cfg_pkg::*;
#(
  parameter int               TOTAL_PADS = 38,
  parameter int               CFG_W      = gpio_cfg_pkg::CFG_W,
  parameter logic [CFG_W-1:0] CFG_INIT   = gpio_cfg_pkg::CFG_INIT,
  parameter int               AW         = (TOTAL_PADS > 1) ? $clog2(TOTAL_PADS) : 1
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    xfer_start,
  output logic                    xfer_busy,
  output logic                    xfer_done,
  output logic                    cfg_rd_en,
  output logic [AW-1:0]           cfg_rd_addr,
  input  logic [CFG_W-1:0]        cfg_rd_data,
  input  logic [TOTAL_PADS-1:0]   mgmt_io_out,
  input  logic [TOTAL_PADS-1:0]   mgmt_oeb,
  input  logic [TOTAL_PADS-1:0]   user_io_out,
  input  logic [TOTAL_PADS-1:0]   user_oeb,
  output logic [TOTAL_PADS-1:0]   io_out,
  output logic [TOTAL_PADS-1:0]   oeb,
  output logic [TOTAL_PADS-1:0]   inp_dis,
  output logic [TOTAL_PADS-1:0]   ib_mode_sel,
  output logic [TOTAL_PADS-1:0]   vtrip_sel,
  output logic [TOTAL_PADS-1:0]   slow_sel,
  output logic [TOTAL_PADS-1:0]   holdover,
  output logic [TOTAL_PADS-1:0]   analog_en,
  output logic [TOTAL_PADS-1:0]   analog_sel,
  output logic [TOTAL_PADS-1:0]   analog_pol,
  output logic [3*TOTAL_PADS-1:0] dm
);

  localparam int SH_W = TOTAL_PADS * CFG_W;
  localparam int BW   = $clog2(CFG_W);

  xfer_state_t       state, state_nxt;
  logic [AW-1:0]     pad_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [CFG_W-1:0]  word;
  logic [SH_W-1:0]   shadow;
  logic              load;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= ST_IDLE;
      pad_cnt <= '0;
      bit_cnt <= '0;
      word    <= CFG_INIT;
      shadow  <= {TOTAL_PADS{CFG_INIT}};
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (xfer_start) pad_cnt <= AW'(TOTAL_PADS - 1);
        end
        ST_CAPTURE: begin
          word    <= cfg_rd_data;
          bit_cnt <= BW'(CFG_W - 1);
        end
        ST_SHIFT: begin
          // The first bit shifted in ends at the top of the chain, so pad N-1
          // (visited first) lands in the highest slice after N*CFG_W shifts.
          shadow  <= {shadow[SH_W-2:0], word[bit_cnt]};
          bit_cnt <= bit_cnt - 1'b1;
          if (bit_cnt == '0 && pad_cnt != '0) pad_cnt <= pad_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    xfer_busy = 1'b1;
    cfg_rd_en = 1'b0;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        xfer_busy = 1'b0;
        if (xfer_start) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        cfg_rd_en = 1'b1;
        state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        if (bit_cnt == '0) state_nxt = (pad_cnt == '0) ? ST_LOAD : ST_FETCH;
      end
      ST_LOAD: begin
        load      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign xfer_done = load;
  // pad_cnt only moves on entry to FETCH, so it doubles as the held read address.
  assign cfg_rd_addr = pad_cnt;

  gpio_cfg_cell #(
    .WORD_W    (CFG_W),
    .WORD_INIT (CFG_INIT)
  ) u_cell [TOTAL_PADS-1:0] (
    .clk         (wb_clk_i),
    .rst         (wb_rst_i),
    .load        (load),
    .shadow_word (shadow),
    .mgmt_io_out (mgmt_io_out),
    .mgmt_oeb    (mgmt_oeb),
    .user_io_out (user_io_out),
    .user_oeb    (user_oeb),
    .io_out      (io_out),
    .oeb         (oeb),
    .inp_dis     (inp_dis),
    .ib_mode_sel (ib_mode_sel),
    .vtrip_sel   (vtrip_sel),
    .slow_sel    (slow_sel),
    .holdover    (holdover),
    .analog_en   (analog_en),
    .analog_sel  (analog_sel),
    .analog_pol  (analog_pol),
    .dm          (dm)
  );

endmodule

// File: tb/tb_gpio_cfg_xfer.sv
// tb/tb_gpio_cfg_xfer.sv - self-checking bench for gpio_cfg_xfer (38-pad and 1-pad builds)
module tb_gpio_cfg_xfer;

  localparam int N = 38;
  localparam logic [12:0] INIT = 13'h0403;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, busy, done, rd_en;
  logic [5:0]  rd_addr;
  logic [12:0] rd_data;
  logic [N-1:0] mgmt_io_out, mgmt_oeb, user_io_out, user_oeb;
  logic [N-1:0] io_out, oeb, inp_dis, ib_mode_sel, vtrip_sel, slow_sel, holdover;
  logic [N-1:0] analog_en, analog_sel, analog_pol;
  logic [3*N-1:0] dm;

  logic s_start, s_busy, s_done, s_rd_en;
  logic [0:0]  s_rd_addr;
  logic [12:0] s_rd_data, s_mem;
  logic s_mgmt_io_out, s_mgmt_oeb, s_user_io_out, s_user_oeb;
  logic s_io_out, s_oeb, s_inp_dis, s_ib_mode_sel, s_vtrip_sel, s_slow_sel, s_holdover;
  logic s_analog_en, s_analog_sel, s_analog_pol;
  logic [2:0] s_dm;

  logic [12:0] mem [N];
  logic [12:0] act_model [N];
  int addr_q[$];
  int checks = 0;
  int failures = 0;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];
  always @(posedge clk) if (s_rd_en) s_rd_data <= s_mem;

  gpio_cfg_xfer #(.TOTAL_PADS(N)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .xfer_start(start), .xfer_busy(busy), .xfer_done(done),
    .cfg_rd_en(rd_en), .cfg_rd_addr(rd_addr), .cfg_rd_data(rd_data),
    .mgmt_io_out(mgmt_io_out), .mgmt_oeb(mgmt_oeb), .user_io_out(user_io_out), .user_oeb(user_oeb),
    .io_out(io_out), .oeb(oeb), .inp_dis(inp_dis), .ib_mode_sel(ib_mode_sel),
    .vtrip_sel(vtrip_sel), .slow_sel(slow_sel), .holdover(holdover), .analog_en(analog_en),
    .analog_sel(analog_sel), .analog_pol(analog_pol), .dm(dm)
  );

  gpio_cfg_xfer #(.TOTAL_PADS(1)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .xfer_start(s_start), .xfer_busy(s_busy), .xfer_done(s_done),
    .cfg_rd_en(s_rd_en), .cfg_rd_addr(s_rd_addr), .cfg_rd_data(s_rd_data),
    .mgmt_io_out(s_mgmt_io_out), .mgmt_oeb(s_mgmt_oeb), .user_io_out(s_user_io_out),
    .user_oeb(s_user_oeb), .io_out(s_io_out), .oeb(s_oeb), .inp_dis(s_inp_dis),
    .ib_mode_sel(s_ib_mode_sel), .vtrip_sel(s_vtrip_sel), .slow_sel(s_slow_sel),
    .holdover(s_holdover), .analog_en(s_analog_en), .analog_sel(s_analog_sel),
    .analog_pol(s_analog_pol), .dm(s_dm)
  );

  function automatic logic [N-1:0] exp_field(input int b);
    logic [N-1:0] r;
    for (int p = 0; p < N; p++) r[p] = act_model[p][b];
    return r;
  endfunction

  function automatic logic [3*N-1:0] exp_dm();
    logic [3*N-1:0] r;
    for (int p = 0; p < N; p++) r[3*p +: 3] = act_model[p][12:10];
    return r;
  endfunction

  function automatic logic [N-1:0] exp_io();
    logic [N-1:0] r;
    for (int p = 0; p < N; p++) r[p] = act_model[p][0] ? mgmt_io_out[p] : user_io_out[p];
    return r;
  endfunction

  function automatic logic [N-1:0] exp_oeb();
    logic [N-1:0] r;
    for (int p = 0; p < N; p++)
      r[p] = act_model[p][0] ? (act_model[p][1] | mgmt_oeb[p]) : user_oeb[p];
    return r;
  endfunction

  task automatic drive_random_pads();
    mgmt_io_out = N'({$urandom(), $urandom()});
    mgmt_oeb    = N'({$urandom(), $urandom()});
    user_io_out = N'({$urandom(), $urandom()});
    user_oeb    = N'({$urandom(), $urandom()});
  endtask

  // Runs one transfer on the 38-pad DUT; optional extra start pulses and a reset
  // at given cycle offsets from the start edge. done_cyc=0 when reset aborted it.
  task automatic do_xfer(input int st1, input int st2, input int rst_at, output int done_cyc);
    logic [3*N-1:0] old_dm;
    int a;
    bit aborted = 0;
    old_dm = exp_dm();
    addr_q.delete();
    for (int p = N - 1; p >= 0; p--) addr_q.push_back(p);
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    done_cyc = -1;
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      @(negedge clk);
      start = (cyc == st1 || cyc == st2);
      if (cyc == 1) begin
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL busy_at_fetch got=%b exp=1", busy); end
      end
      if (rd_en) begin
        checks++;
        if (addr_q.size() == 0) begin
          failures++; $display("FAIL rd_addr_extra got=%0d exp=none", rd_addr);
        end else begin
          a = addr_q.pop_front();
          if (rd_addr !== 6'(a)) begin failures++; $display("FAIL rd_addr_seq got=%0d exp=%0d", rd_addr, a); end
        end
      end
      if (cyc == 300) begin
        checks++;
        if (dm !== old_dm) begin failures++; $display("FAIL dm_before_load got=%h exp=%h", dm, old_dm); end
      end
      if (cyc == rst_at) begin
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        for (int p = 0; p < N; p++) act_model[p] = INIT;
        checks++;
        if (dm !== {N{3'b001}}) begin failures++; $display("FAIL rst_mid_dm got=%h exp=%h", dm, {N{3'b001}}); end
        checks++;
        if (oeb !== {N{1'b1}}) begin failures++; $display("FAIL rst_mid_oeb got=%h exp=%h", oeb, {N{1'b1}}); end
        checks++;
        if (io_out !== mgmt_io_out) begin failures++; $display("FAIL rst_mid_io got=%h exp=%h", io_out, mgmt_io_out); end
        checks++;
        if ({busy, done} !== 2'b00) begin failures++; $display("FAIL rst_mid_busy_done got=%b exp=00", {busy, done}); end
        for (int k = 0; k < 600; k++) begin
          @(negedge clk);
          if (done || rd_en) begin
            failures++; $display("FAIL rst_mid_activity got done=%b rd_en=%b exp=0", done, rd_en);
            break;
          end
        end
        checks++;
        addr_q.delete();
        done_cyc = 0;
        aborted = 1;
        break;
      end
      if (done) begin
        done_cyc = cyc;
        checks++;
        if (dm !== old_dm) begin failures++; $display("FAIL dm_during_load got=%h exp=%h", dm, old_dm); end
        break;
      end
    end
    if (!aborted) begin
      if (done_cyc < 0) begin
        checks++; failures++; $display("FAIL xfer_timeout got=none exp=done");
      end else begin
        for (int p = 0; p < N; p++) act_model[p] = mem[p];
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin failures++; $display("FAIL after_done got=%b exp=00", {busy, done}); end
        checks++;
        if (addr_q.size() != 0) begin failures++; $display("FAIL rd_addr_missing got=%0d exp=0", addr_q.size()); end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; s_start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; start = 1'b0;
    for (int p = 0; p < N; p++) act_model[p] = INIT;
    checks++;
    if (oeb !== {N{1'b1}}) begin failures++; $display("FAIL reset_oeb got=%h exp=%h", oeb, {N{1'b1}}); end
    checks++;
    if (dm !== {N{3'b001}}) begin failures++; $display("FAIL reset_dm got=%h exp=%h", dm, {N{3'b001}}); end
    checks++;
    if (inp_dis !== '0) begin failures++; $display("FAIL reset_inp_dis got=%h exp=0", inp_dis); end
    checks++;
    if ({busy, done, rd_en, rd_addr} !== 9'd0) begin
      failures++; $display("FAIL reset_ctrl got=%b%b%b/%0d exp=000/0", busy, done, rd_en, rd_addr);
    end
    checks++;
    if (s_dm !== 3'b001 || s_oeb !== 1'b1) begin failures++; $display("FAIL reset_small got dm=%b oeb=%b exp=001/1", s_dm, s_oeb); end
    for (int i = 0; i < 4; i++) begin
      drive_random_pads();
      #1;
      checks++;
      if (io_out !== mgmt_io_out) begin failures++; $display("FAIL reset_io_track got=%h exp=%h", io_out, mgmt_io_out); end
    end
  endtask

  task automatic test_full_xfer();
    int dc;
    for (int p = 0; p < N; p++) mem[p] = 13'h1000 | 13'(p);
    do_xfer(-1, -1, -1, dc);
    checks++;
    if (dc != 571) begin failures++; $display("FAIL full_done_cycle got=%0d exp=571", dc); end
    checks++;
    if (dm !== {N{3'b100}}) begin failures++; $display("FAIL full_dm got=%h exp=%h", dm, {N{3'b100}}); end
    checks++;
    if ({holdover, inp_dis, ib_mode_sel, analog_en} !== {exp_field(2), exp_field(3), exp_field(4), exp_field(5)}) begin
      failures++; $display("FAIL full_fields_lo got=%h %h %h %h exp=%h %h %h %h", holdover, inp_dis,
        ib_mode_sel, analog_en, exp_field(2), exp_field(3), exp_field(4), exp_field(5));
    end
    checks++;
    if ({analog_sel, analog_pol, slow_sel, vtrip_sel} !== {exp_field(6), exp_field(7), exp_field(8), exp_field(9)}) begin
      failures++; $display("FAIL full_fields_hi got=%h %h %h %h exp=%h %h %h %h", analog_sel, analog_pol,
        slow_sel, vtrip_sel, exp_field(6), exp_field(7), exp_field(8), exp_field(9));
    end
    drive_random_pads();
    #1;
    checks++;
    if (io_out !== exp_io()) begin failures++; $display("FAIL full_io got=%h exp=%h", io_out, exp_io()); end
    checks++;
    if (oeb !== exp_oeb()) begin failures++; $display("FAIL full_oeb got=%h exp=%h", oeb, exp_oeb()); end
  endtask

  task automatic test_ownership();
    int dc;
    for (int p = 0; p < N; p++) mem[p] = INIT;
    mem[5] = 13'h0000;
    mem[6] = 13'h0001;
    do_xfer(-1, -1, -1, dc);
    checks++;
    if (dc != 571) begin failures++; $display("FAIL own_done_cycle got=%0d exp=571", dc); end
    for (int i = 0; i < 4; i++) begin
      drive_random_pads();
      #1;
      checks++;
      if ({io_out[5], oeb[5]} !== {user_io_out[5], user_oeb[5]}) begin
        failures++; $display("FAIL own_pad5 got=%b%b exp=%b%b", io_out[5], oeb[5], user_io_out[5], user_oeb[5]);
      end
      checks++;
      if ({io_out[6], oeb[6]} !== {mgmt_io_out[6], mgmt_oeb[6]}) begin
        failures++; $display("FAIL own_pad6 got=%b%b exp=%b%b", io_out[6], oeb[6], mgmt_io_out[6], mgmt_oeb[6]);
      end
      checks++;
      if (oeb !== exp_oeb()) begin failures++; $display("FAIL own_oeb_all got=%h exp=%h", oeb, exp_oeb()); end
    end
  endtask

  task automatic test_start_ignored();
    int dc;
    for (int p = 0; p < N; p++) mem[p] = 13'($urandom());
    do_xfer(10, 300, -1, dc);
    checks++;
    if (dc != 571) begin failures++; $display("FAIL restart_done_cycle got=%0d exp=571", dc); end
    checks++;
    if (dm !== exp_dm()) begin failures++; $display("FAIL restart_dm got=%h exp=%h", dm, exp_dm()); end
    checks++;
    if (inp_dis !== exp_field(3)) begin failures++; $display("FAIL restart_inp_dis got=%h exp=%h", inp_dis, exp_field(3)); end
  endtask

  task automatic test_reset_mid();
    int dc;
    for (int p = 0; p < N; p++) mem[p] = 13'($urandom());
    do_xfer(-1, -1, 200, dc);
    for (int p = 0; p < N; p++) mem[p] = 13'($urandom());
    do_xfer(-1, -1, -1, dc);
    checks++;
    if (dc != 571) begin failures++; $display("FAIL post_rst_done_cycle got=%0d exp=571", dc); end
    checks++;
    if (dm !== exp_dm()) begin failures++; $display("FAIL post_rst_dm got=%h exp=%h", dm, exp_dm()); end
    checks++;
    if (vtrip_sel !== exp_field(9)) begin failures++; $display("FAIL post_rst_vtrip got=%h exp=%h", vtrip_sel, exp_field(9)); end
  endtask

  task automatic test_single_pad();
    int dc = -1;
    s_mem = 13'h0B6E;
    s_mgmt_io_out = 1'b1; s_mgmt_oeb = 1'b0; s_user_io_out = 1'b0; s_user_oeb = 1'b1;
    @(negedge clk); s_start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      s_start = 1'b0;
      if (s_rd_en) begin
        checks++;
        if (s_rd_addr !== 1'b0) begin failures++; $display("FAIL small_addr got=%0d exp=0", s_rd_addr); end
      end
      if (s_done) begin dc = cyc; break; end
    end
    checks++;
    if (dc != 16) begin failures++; $display("FAIL small_done_cycle got=%0d exp=16", dc); end
    @(negedge clk);
    checks++;
    if (s_dm !== s_mem[12:10]) begin failures++; $display("FAIL small_dm got=%b exp=%b", s_dm, s_mem[12:10]); end
    checks++;
    if ({s_holdover, s_inp_dis, s_ib_mode_sel, s_analog_en, s_analog_sel, s_analog_pol, s_slow_sel, s_vtrip_sel}
        !== {s_mem[2], s_mem[3], s_mem[4], s_mem[5], s_mem[6], s_mem[7], s_mem[8], s_mem[9]}) begin
      failures++; $display("FAIL small_fields got=%b%b%b%b%b%b%b%b exp=%b", s_holdover, s_inp_dis, s_ib_mode_sel,
        s_analog_en, s_analog_sel, s_analog_pol, s_slow_sel, s_vtrip_sel, s_mem[9:2]);
    end
    checks++;
    if ({s_io_out, s_oeb} !== {s_user_io_out, s_user_oeb}) begin
      failures++; $display("FAIL small_mux got=%b%b exp=%b%b", s_io_out, s_oeb, s_user_io_out, s_user_oeb);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; s_start = 1'b0;
    mgmt_io_out = '0; mgmt_oeb = '0; user_io_out = '0; user_oeb = '0;
    s_mgmt_io_out = 1'b0; s_mgmt_oeb = 1'b0; s_user_io_out = 1'b0; s_user_oeb = 1'b0;
    s_mem = '0;
    test_reset();
    test_full_xfer();
    test_ownership();
    test_start_ignored();
    test_reset_mid();
    test_single_pad();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
